// File: rtl/fc_pkg.sv
// fc_pkg: shared types and helpers for the streaming fully-connected classifier.
// Provides the control-state enum, width helpers and a generic signed saturator.
// No logic of its own; used by fc_requant and fc_classifier_stream.
package fc_pkg;

  typedef enum logic [2:0] {
    ACCUM,
    DRAIN,
    SCALE,
    ARGMAX,
    HOLD
  } fc_state_e;

  // Never returns zero so that a degenerate size still yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int class_w(input int n_out);
    return clog2_min1(n_out);
  endfunction

  function automatic int cnt_w(input int n_in);
    return clog2_min1(n_in);
  endfunction

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [127:0] sat(input logic signed [127:0] x, input int w);
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// fc_requant: one requantisation lane, score = sat((acc * MULTIPLIER) >>> SHIFT).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of acc_i.
// Ports: acc_i (signed accumulator, ACC_W), score_o (signed saturated score, DATA_W).
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 8,
  parameter int MULTIPLIER = 200000,
  parameter int SHIFT      = 16
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] score_o
);

  // Product is kept at ACC_W+32 bits so the multiply can never wrap.
  localparam int PW = ACC_W + 32;
  localparam logic signed [31:0] MULT = 32'(MULTIPLIER);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  assign prod    = PW'(acc_i) * PW'(MULT);
  assign shifted = prod >>> SHIFT;
  assign score_o = DATA_W'(sat(128'(shifted), DATA_W));

endmodule

// File: rtl/fc_classifier_stream.sv
// fc_classifier_stream: streaming FC output layer, N_OUT parallel dot products, requant, sequential argmax.
// Latency: out_valid rises N_OUT+3 cycles after the edge accepting the final beat of a frame.
// Backpressure: in_ready only in ACCUM; result held in HOLD until out_ready, no input accepted meanwhile.
// Ports: clk, rst (async active-high), weights_flat, in_valid/in_ready/in_data/in_last,
//        out_valid/out_ready/out_class/out_score, frame_err (one-cycle pulse on in_last mismatch).
// Optional: define FC_BIAS_EN to add bias_flat; bias[n] is added when beat 0 lands in the accumulator.
module fc_classifier_stream
  import fc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int N_IN       = 48,
  parameter int N_OUT      = 10,
  parameter int ACC_W      = 32,
  parameter int MULTIPLIER = 200000,
  parameter int SHIFT      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W*N_IN*N_OUT-1:0]  weights_flat,
`ifdef FC_BIAS_EN
  input  logic [ACC_W*N_OUT-1:0]        bias_flat,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(N_OUT)-1:0]      out_class,
  output logic [DATA_W-1:0]             out_score,
  output logic                          frame_err
);

  localparam int CLASS_W = class_w(N_OUT);
  localparam int CNT_W   = cnt_w(N_IN);
  localparam int PW2     = 2 * DATA_W;

  fc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CLASS_W-1:0] step_q, step_d;
  logic               run_q;
  logic               frame_err_q, frame_err_d;
  logic               accept;
  logic               last_beat;

  logic signed [DATA_W-1:0] w_sel   [N_OUT];
  logic signed [PW2-1:0]    mul_w   [N_OUT];
  logic signed [ACC_W-1:0]  bias_w  [N_OUT];
  logic signed [ACC_W-1:0]  prod_q  [N_OUT];
  logic signed [ACC_W-1:0]  acc_q   [N_OUT];
  logic signed [DATA_W-1:0] score_w [N_OUT];
  logic signed [DATA_W-1:0] score_q [N_OUT];
  logic                     p1_vld_q;
  logic                     p1_first_q;
  logic [CLASS_W-1:0]       best_cls_q;
  logic signed [DATA_W-1:0] best_score_q;

  // run_q keeps in_ready low while reset is held and for the reset-release edge.
  assign in_ready  = run_q && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(N_IN - 1));
  assign out_valid = (state_q == HOLD);
  assign out_class = best_cls_q;
  assign out_score = best_score_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    frame_err_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            state_d     = DRAIN;
            cnt_d       = '0;
            step_d      = '0;
            frame_err_d = !in_last;
          end else if (in_last) begin
            // Short frame: drop it; the next beat 0 overwrites the accumulators.
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (step_q == CLASS_W'(1)) begin
          state_d = SCALE;
          step_d  = '0;
        end else begin
          step_d = step_q + CLASS_W'(1);
        end
      end
      SCALE: begin
        state_d = ARGMAX;
        step_d  = '0;
      end
      ARGMAX: begin
        // Step 0 seeds the running max with lane 0, steps 1..N_OUT-1 compare.
        if (step_q == CLASS_W'(N_OUT - 1)) begin
          state_d = HOLD;
        end else begin
          step_d = step_q + CLASS_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      step_q      <= '0;
      run_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      run_q       <= 1'b1;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      w_sel[n] = weights_flat[(n*N_IN + int'(cnt_q))*DATA_W +: DATA_W];
      mul_w[n] = PW2'($signed(in_data)) * PW2'(w_sel[n]);
`ifdef FC_BIAS_EN
      bias_w[n] = bias_flat[n*ACC_W +: ACC_W];
`else
      bias_w[n] = '0;
`endif
    end
  end

  // Stage 1 registers the products, stage 2 accumulates; only accepted beats move the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      for (int n = 0; n < N_OUT; n++) begin
        prod_q[n]  <= '0;
        acc_q[n]   <= '0;
        score_q[n] <= '0;
      end
    end else begin
      p1_vld_q   <= accept;
      p1_first_q <= (cnt_q == '0);
      for (int n = 0; n < N_OUT; n++) begin
        if (accept) prod_q[n] <= ACC_W'(mul_w[n]);
        if (p1_vld_q) acc_q[n] <= p1_first_q ? (prod_q[n] + bias_w[n]) : (acc_q[n] + prod_q[n]);
        if (state_q == SCALE) score_q[n] <= score_w[n];
      end
    end
  end

  for (genvar n = 0; n < N_OUT; n++) begin : g_rq
    fc_requant #(
      .ACC_W      (ACC_W),
      .DATA_W     (DATA_W),
      .MULTIPLIER (MULTIPLIER),
      .SHIFT      (SHIFT)
    ) u_rq (
      .acc_i   (acc_q[n]),
      .score_o (score_w[n])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_cls_q   <= '0;
      best_score_q <= '0;
    end else if (state_q == ARGMAX) begin
      if (step_q == '0) begin
        best_cls_q   <= '0;
        best_score_q <= score_q[0];
      end else if (score_q[step_q] > best_score_q) begin
        best_cls_q   <= step_q;
        best_score_q <= score_q[step_q];
      end
    end
  end

endmodule
